// File: rtl/sel_encode_pkg.sv
// Shared field positions, register index type and index-to-one-hot helper for the select/encode slice.
package sel_encode_pkg;
  localparam int RA_LSB   = 23;
  localparam int RB_LSB   = 19;
  localparam int RC_LSB   = 15;
  localparam int C_W      = 19;
  localparam int MAX_REGS = 32;

  // Wide enough for the largest register file.
  typedef logic [$clog2(MAX_REGS)-1:0] reg_idx_t;

  function automatic logic [MAX_REGS-1:0] idx2onehot(input reg_idx_t idx);
    idx2onehot = '0;
    idx2onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/sel_scoreboard.sv
// Pending-load scoreboard: set wins over a same-address clear; hazard bypasses a completing write-back.
// 1-cycle registered outputs; no backpressure, every cycle is accepted.
module sel_scoreboard import sel_encode_pkg::*; #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [NUM_REGS-1:0] sel_oh,
  input  logic                ld_issue,
  input  logic                rd_en,
  input  logic                wb_done,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] pending,
  output logic                hazard
);
  logic [MAX_REGS-1:0] wb_full;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] pending_d;
  logic                hazard_d;
  logic                unused_wb;

  // sel_oh is already zero when nothing valid is selected; an out-of-range wb_addr
  // lands above NUM_REGS and drops out of the slice.
  always_comb begin
    wb_full   = idx2onehot(reg_idx_t'(wb_addr));
    clr_vec   = wb_done ? wb_full[NUM_REGS-1:0] : '0;
    set_vec   = ld_issue ? sel_oh : '0;
    pending_d = (pending & ~clr_vec) | set_vec;
    hazard_d  = rd_en & (|(pending & sel_oh & ~clr_vec));
  end

  assign unused_wb = ^wb_full;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pending <= '0;
      hazard  <= 1'b0;
    end else begin
      pending <= pending_d;
      hazard  <= hazard_d;
    end
  end
endmodule

// File: rtl/sel_encode_sb.sv
// Registered ra/rb/rc select/encode with R0 substitution, C sign-extension and load scoreboard; 1-cycle latency.
// No backpressure. Build option SELENC_ONEHOT_CHECK_EN adds the sticky sel_err output.
module sel_encode_sb
  import sel_encode_pkg::reg_idx_t;
  import sel_encode_pkg::idx2onehot;
  import sel_encode_pkg::MAX_REGS;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int IR_W     = 32,
  parameter int RA_LSB   = sel_encode_pkg::RA_LSB,
  parameter int RB_LSB   = sel_encode_pkg::RB_LSB,
  parameter int RC_LSB   = sel_encode_pkg::RC_LSB,
  parameter int C_W      = sel_encode_pkg::C_W
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic [IR_W-1:0]     ir,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  input  logic                ld_issue,
  input  logic                wb_done,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                ba_zero,
  output logic [31:0]         c_sext,
  output logic [NUM_REGS-1:0] pending,
  output logic                hazard
`ifdef SELENC_ONEHOT_CHECK_EN
  ,
  output logic                sel_err
`endif
);
  logic [ADDR_W-1:0]   ra, rb, rc;
  reg_idx_t            sel;
  logic                any_g;
  logic                sel_ok;
  logic                r0_sub;
  logic                rd_en;
  logic [MAX_REGS-1:0] oh_full;
  logic [NUM_REGS-1:0] sel_oh;
  logic [NUM_REGS-1:0] reg_in_d;
  logic [NUM_REGS-1:0] reg_out_d;
  logic [31:0]         c_sext_d;
  logic                unused_ir;

  assign ra = ir[RA_LSB +: ADDR_W];
  assign rb = ir[RB_LSB +: ADDR_W];
  assign rc = ir[RC_LSB +: ADDR_W];

  // An index at or above NUM_REGS leaves sel_oh empty, which suppresses every output and the scoreboard.
  always_comb begin
    sel = '0;
    if (gra)      sel = reg_idx_t'(ra);
    else if (grb) sel = reg_idx_t'(rb);
    else if (grc) sel = reg_idx_t'(rc);
    any_g     = gra | grb | grc;
    oh_full   = idx2onehot(sel);
    sel_oh    = any_g ? oh_full[NUM_REGS-1:0] : '0;
    sel_ok    = |sel_oh;
    r0_sub    = baout & sel_ok & (sel == '0);
    rd_en     = (rout | baout) & sel_ok & ~r0_sub;
    reg_in_d  = rin ? sel_oh : '0;
    reg_out_d = rd_en ? sel_oh : '0;
    c_sext_d  = {{(32-C_W){ir[C_W-1]}}, ir[C_W-1:0]};
  end

  assign unused_ir = ^{ir, oh_full};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      reg_in  <= '0;
      reg_out <= '0;
      ba_zero <= 1'b0;
      c_sext  <= '0;
    end else begin
      reg_in  <= reg_in_d;
      reg_out <= reg_out_d;
      ba_zero <= r0_sub;
      c_sext  <= c_sext_d;
    end
  end

  sel_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .clr_n    (clr_n),
    .sel_oh   (sel_oh),
    .ld_issue (ld_issue),
    .rd_en    (rd_en),
    .wb_done  (wb_done),
    .wb_addr  (wb_addr),
    .pending  (pending),
    .hazard   (hazard)
  );

`ifdef SELENC_ONEHOT_CHECK_EN
  logic multi_g;
  assign multi_g = ((gra & grb) | (gra & grc) | (grb & grc)) & (rin | rout | baout);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       sel_err <= 1'b0;
    else if (multi_g) sel_err <= 1'b1;
  end
`endif
endmodule
